// File: rtl/rf_write_arbiter.sv
// Round-robin owner of the register-file write port, shared by core writeback (C) and debug (D),
// with a scrub sequencer that zeroes x1..x(NUM_REGS-1) without a global reset.
module rf_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              scrub_start_i,
  output logic              scrub_busy_o,
  output logic              scrub_done_o,
  input  logic              c_valid_i,
  output logic              c_ready_o,
  input  logic [ADDR_W-1:0] c_addr_i,
  input  logic [DATA_W-1:0] c_data_i,
  input  logic              d_valid_i,
  output logic              d_ready_o,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_data_i,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o
);

  typedef enum logic {IDLE, SCRUB} state_t;
  typedef enum logic {RR_C, RR_D} rr_t;

  localparam logic [ADDR_W-1:0] SCRUB_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] SCRUB_LAST  = ADDR_W'(NUM_REGS - 1);

  state_t              state_q, state_d;
  rr_t                 rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]   scrub_cnt_q, scrub_cnt_d;
  logic                rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic                scrub_done_q, scrub_done_d;
  logic                c_grant, d_grant;
  logic                scrub_last;

  assign scrub_last = (scrub_cnt_q == SCRUB_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      rr_ptr_q     <= RR_C;
      scrub_cnt_q  <= SCRUB_FIRST;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      scrub_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      scrub_cnt_q  <= scrub_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      scrub_done_q <= scrub_done_d;
    end
  end

  // A scrub request in IDLE outranks both requesters for that cycle.
  always_comb begin
    c_grant = 1'b0;
    d_grant = 1'b0;
    if (state_q == IDLE && !scrub_start_i) begin
      if (c_valid_i && (!d_valid_i || rr_ptr_q == RR_C)) begin
        c_grant = 1'b1;
      end else if (d_valid_i) begin
        d_grant = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (scrub_start_i) state_d = SCRUB;
      SCRUB:   if (scrub_last)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    scrub_cnt_d  = scrub_cnt_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    scrub_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (scrub_start_i) begin
          scrub_cnt_d = SCRUB_FIRST;
        end else if (c_grant) begin
          rf_we_d    = (c_addr_i != '0);
          rf_waddr_d = c_addr_i;
          rf_wdata_d = c_data_i;
          rr_ptr_d   = RR_D;
        end else if (d_grant) begin
          rf_we_d    = (d_addr_i != '0);
          rf_waddr_d = d_addr_i;
          rf_wdata_d = d_data_i;
          rr_ptr_d   = RR_C;
        end
      end
      SCRUB: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = scrub_cnt_q;
        rf_wdata_d = '0;
        if (scrub_last) begin
          scrub_done_d = 1'b1;
          scrub_cnt_d  = SCRUB_FIRST;
        end else begin
          scrub_cnt_d = scrub_cnt_q + SCRUB_FIRST;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    c_ready_o    = c_grant;
    d_ready_o    = d_grant;
    scrub_busy_o = (state_q == SCRUB);
    scrub_done_o = scrub_done_q;
    rf_we_o      = rf_we_q;
    rf_waddr_o   = rf_waddr_q;
    rf_wdata_o   = rf_wdata_q;
  end

endmodule
